// File: rtl/spi_reg_ctrl.sv
// Frame-level SPI register controller: command decode, burst register
// writes and prefetched reads behind a byte-level SPI slave datapath.
module spi_reg_ctrl #(
    parameter int          ADDR_W    = 7,
    parameter bit          AUTO_INC  = 1'b1,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spi_ss,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        byte_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    state_t            state_nx;
    logic              we_q;
    logic              re_q;
    logic              rd_pend;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!spi_ss) state_nx = CMD;
            CMD: begin
                if (rx_valid) state_nx = rx_byte[7] ? RD : WR;
            end
            WR: state_nx = WR;
            RD: state_nx = RD;
        endcase
        if (spi_ss) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            rd_pend   <= 1'b0;
            tx_q      <= IDLE_BYTE;
            addr_q    <= '0;
            reg_wdata <= 8'h00;
            byte_cnt  <= 8'h00;
        end else if (ena) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rd_pend <= re_q;
            // Write bursts advance the address once the strobe has been seen
            if (we_q && AUTO_INC) addr_q <= addr_q + ADDR_ONE;
            if (spi_ss) begin
                tx_q     <= IDLE_BYTE;
                byte_cnt <= 8'h00;
            end else begin
                if (rd_pend && state == RD) tx_q <= reg_rdata;
                if (rx_valid && state == CMD) begin
                    addr_q <= rx_byte[ADDR_W-1:0];
                    re_q   <= rx_byte[7];
                end
                if (rx_valid && state == WR) begin
                    we_q      <= 1'b1;
                    reg_wdata <= rx_byte;
                    if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                end
                if (rx_valid && state == RD) begin
                    re_q <= 1'b1;
                    if (AUTO_INC) addr_q <= addr_q + ADDR_ONE;
                    if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                end
            end
        end
    end

    // Read data is forwarded in the cycle it arrives, then held in tx_q
    assign tx_byte  = (rd_pend && state == RD) ? reg_rdata : tx_q;
    assign reg_we   = we_q & ena;
    assign reg_re   = re_q & ena;
    assign reg_addr = addr_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed table-driven bench for spi_reg_ctrl with a simple
// synchronous register-file model on the register bus.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       spi_ss;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [7:0] byte_cnt;

    spi_reg_ctrl dut (
        .clk(clk), .rst(rst), .ena(ena), .spi_ss(spi_ss),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_byte(tx_byte),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ena, ss, rv;
        logic [7:0] rb;
        logic       we, re;
        logic [7:0] addr, wd, tx;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] mem [128];
    int         n_pass = 0;
    int         n_tot  = 0;
    int         we_seen = 0;
    int         re_seen = 0;
    int         overlap = 0;

    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_we) we_seen++;
        if (reg_re) re_seen++;
        if (reg_we && reg_re) overlap++;
    end

    function automatic vec_t mk(logic e, logic s, logic v, logic [7:0] b,
                                logic w, logic r, logic [7:0] a,
                                logic [7:0] d, logic [7:0] t, logic bz,
                                logic [7:0] c);
        vec_t x;
        x.ena = e; x.ss = s; x.rv = v; x.rb = b;
        x.we = w; x.re = r; x.addr = a; x.wd = d; x.tx = t;
        x.busy = bz; x.cnt = c;
        return x;
    endfunction

    task automatic check(input string nm, input vec_t x);
        logic ok;
        ok = (reg_we === x.we) && (reg_re === x.re) &&
             ({1'b0, reg_addr} === x.addr) && (reg_wdata === x.wd) &&
             (tx_byte === x.tx) && (busy === x.busy) &&
             (byte_cnt === x.cnt);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got we=%b re=%b addr=%h wd=%h tx=%h busy=%b cnt=%h want we=%b re=%b addr=%h wd=%h tx=%h busy=%b cnt=%h",
            nm, reg_we, reg_re, reg_addr, reg_wdata, tx_byte, busy,
            byte_cnt, x.we, x.re, x.addr, x.wd, x.tx, x.busy, x.cnt);
    endtask

    task automatic step(input vec_t x);
        ena = x.ena; spi_ss = x.ss; rx_valid = x.rv; rx_byte = x.rb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string nm, input int got, input int want);
        n_tot++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'h22;
        reg_rdata = 8'h00;
        rst = 1'b0; ena = 1'b1; spi_ss = 1'b0; rx_valid = 1'b1;
        rx_byte = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset", mk(1,0,1,8'hFF, 0,0,8'h00,8'h00,8'h00,0,8'h00));
        spi_ss = 1'b1; rx_valid = 1'b0;
        #1 rst = 1'b1;

        // write burst
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h00,8'h00,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'h05, 0,0,8'h05,8'h00,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h05,8'h00,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h05,8'h00,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'hAA, 1,0,8'h05,8'hAA,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h06,8'hAA,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h06,8'hAA,8'h00,1,1));
        vq.push_back(mk(1,0,1,8'h55, 1,0,8'h06,8'h55,8'h00,1,2));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h07,8'h55,8'h00,1,2));
        vq.push_back(mk(1,1,0,8'h00, 0,0,8'h07,8'h55,8'h00,0,0));
        // read burst with prefetch
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h07,8'h55,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'h90, 0,1,8'h10,8'h55,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h10,8'h55,8'h11,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h10,8'h55,8'h11,1,0));
        vq.push_back(mk(1,0,1,8'h00, 0,1,8'h11,8'h55,8'h11,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h11,8'h55,8'h22,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h11,8'h55,8'h22,1,1));
        vq.push_back(mk(1,1,0,8'h00, 0,0,8'h11,8'h55,8'h00,0,0));
        // address wrap
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h11,8'h55,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'h7F, 0,0,8'h7F,8'h55,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h7F,8'h55,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h7F,8'h55,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'hA1, 1,0,8'h7F,8'hA1,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h00,8'hA1,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h00,8'hA1,8'h00,1,1));
        vq.push_back(mk(1,0,1,8'hB2, 1,0,8'h00,8'hB2,8'h00,1,2));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h01,8'hB2,8'h00,1,2));
        vq.push_back(mk(1,1,0,8'h00, 0,0,8'h01,8'hB2,8'h00,0,0));
        // abort on 2nd data byte
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h01,8'hB2,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'h03, 0,0,8'h03,8'hB2,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h03,8'hB2,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h03,8'hB2,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'hC3, 1,0,8'h03,8'hC3,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h04,8'hC3,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h04,8'hC3,8'h00,1,1));
        vq.push_back(mk(1,1,1,8'hD4, 0,0,8'h04,8'hC3,8'h00,0,0));
        vq.push_back(mk(1,1,0,8'h00, 0,0,8'h04,8'hC3,8'h00,0,0));
        // clock-enable stall mid write burst
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h04,8'hC3,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'h08, 0,0,8'h08,8'hC3,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h08,8'hC3,8'h00,1,0));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h08,8'hC3,8'h00,1,0));
        vq.push_back(mk(1,0,1,8'hE5, 1,0,8'h08,8'hE5,8'h00,1,1));
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(0,0,(i == 4),8'hF6, 0,0,8'h08,8'hE5,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h09,8'hE5,8'h00,1,1));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h09,8'hE5,8'h00,1,1));
        vq.push_back(mk(1,0,1,8'hF7, 1,0,8'h09,8'hF7,8'h00,1,2));
        vq.push_back(mk(1,0,0,8'h00, 0,0,8'h0A,8'hF7,8'h00,1,2));
        vq.push_back(mk(1,1,0,8'h00, 0,0,8'h0A,8'hF7,8'h00,0,0));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i]);
            check($sformatf("vec%0d", i), vq[i]);
        end

        // async reset mid-frame, then a read frame right after release
        step(mk(1,0,0,8'h00, 0,0,0,0,0,0,0));
        step(mk(1,0,1,8'h06, 0,0,0,0,0,0,0));
        check("pre_rst", mk(1,0,1,8'h06, 0,0,8'h06,8'hF7,8'h00,1,0));
        rx_valid = 1'b0;
        rst = 1'b0;
        #2;
        check("mid_rst", mk(1,0,0,8'h00, 0,0,8'h00,8'h00,8'h00,0,0));
        rst = 1'b1;
        step(mk(1,0,0,8'h00, 0,0,0,0,0,0,0));
        check("post_rst", mk(1,0,0,8'h00, 0,0,8'h00,8'h00,8'h00,1,0));
        step(mk(1,0,1,8'h85, 0,0,0,0,0,0,0));
        check("rd_cmd", mk(1,0,1,8'h85, 0,1,8'h05,8'h00,8'h00,1,0));
        step(mk(1,0,0,8'h00, 0,0,0,0,0,0,0));
        check("rd_tx", mk(1,0,0,8'h00, 0,0,8'h05,8'h00,8'hAA,1,0));
        step(mk(1,1,0,8'h00, 0,0,0,0,0,0,0));
        check("rd_end", mk(1,1,0,8'h00, 0,0,8'h05,8'h00,8'h00,0,0));

        chk_val("mem05", mem[7'h05], 8'hAA);
        chk_val("mem06", mem[7'h06], 8'h55);
        chk_val("mem7f", mem[7'h7F], 8'hA1);
        chk_val("mem00", mem[7'h00], 8'hB2);
        chk_val("mem03", mem[7'h03], 8'hC3);
        chk_val("mem04", mem[7'h04], 8'h00);
        chk_val("mem08", mem[7'h08], 8'hE5);
        chk_val("mem09", mem[7'h09], 8'hF7);
        chk_val("we_count", we_seen, 7);
        chk_val("re_count", re_seen, 3);
        chk_val("overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
